// File: rtl/console_writer_if.sv
// Bundle between a byte source (e.g. UART RX) and console_writer, plus the
// text-buffer write port and cursor/scroll status the writer drives.
// slave  : the console_writer side.
// master : the byte source / buffer / display side.
interface console_writer_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [6:0]        cursor_x;
  logic [4:0]        cursor_y;
  logic [4:0]        scroll_row;

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, scroll_row
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, cursor_x, cursor_y, scroll_row
  );
endinterface

// File: rtl/console_writer.sv
// console_writer: turns a byte stream into writes on the single write port of
// an 80x30 text buffer (address = y*COLS + x). Tracks the cursor, handles
// CR / LF / BS, blanks the whole buffer after reset and blanks each new line
// before text lands on it.
// Optional build macro CONSOLE_SCROLL_EN: once the cursor has wrapped from the
// bottom row, scroll_row follows it so the newest line shows at the bottom.
// Without the macro scroll_row is tied to 0.
module console_writer #(
  parameter int          COLS   = 80,
  parameter int          ROWS   = 30,
  parameter int          ADDR_W = 12,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic             clk,
  input  logic             rst,
  console_writer_if.slave  bus
);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_LINE} state_t;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] LINE_END  = ADDR_W'(COLS-1);
  localparam logic [6:0]        LAST_COL  = 7'(COLS-1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS-1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [6:0]        cx_q, cx_d;
  logic [4:0]        cy_q, cy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              row_adv;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] cur_addr;

  // Base address of the cursor row; in CLEAR_LINE this is already the new row.
  assign row_base = ADDR_W'(cy_q) * ADDR_W'(COLS);
  assign cur_addr = row_base + ADDR_W'(cx_q);

  assign bus.in_ready = (state_q == IDLE);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.cursor_x = cx_q;
  assign bus.cursor_y = cy_q;

  // State, cursor and write-port registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= CLEAR_ALL;
      cnt_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next state: clears, character decode and the shared row-advance step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    row_adv   = 1'b0;
    case (state_q)
      CLEAR_ALL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = BLANK;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_CELL) state_d = IDLE;
      end
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = bus.in_data;
            if (cx_q == LAST_COL) begin
              cx_d    = '0;
              row_adv = 1'b1;
            end else begin
              cx_d = cx_q + 7'd1;
            end
          end else if (bus.in_data == 8'h0A) begin
            cx_d    = '0;
            row_adv = 1'b1;
          end else if (bus.in_data == 8'h0D) begin
            cx_d = '0;
          end else if (bus.in_data == 8'h08) begin
            if (cx_q != '0) cx_d = cx_q - 7'd1;
          end
        end
      end
      CLEAR_LINE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = row_base + cnt_q;
        wr_data_d = BLANK;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == LINE_END) state_d = IDLE;
      end
      default: state_d = CLEAR_ALL;
    endcase
    if (row_adv) begin
      cy_d    = (cy_q == LAST_ROW) ? 5'd0 : cy_q + 5'd1;
      state_d = CLEAR_LINE;
      cnt_d   = '0;
    end
  end

`ifdef CONSOLE_SCROLL_EN
  logic       wrapped_q, wrapped_d;
  logic [4:0] scroll_q, scroll_d;

  // Scroll tracking: after the first bottom-to-top wrap, the row just below
  // the cursor is the oldest line and becomes the display top.
  always_comb begin
    wrapped_d = wrapped_q;
    scroll_d  = scroll_q;
    if (row_adv) begin
      if (cy_q == LAST_ROW) wrapped_d = 1'b1;
      if (wrapped_d) scroll_d = (cy_d == LAST_ROW) ? 5'd0 : cy_d + 5'd1;
    end
  end

  // Scroll registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrapped_q <= 1'b0;
      scroll_q  <= '0;
    end else begin
      wrapped_q <= wrapped_d;
      scroll_q  <= scroll_d;
    end
  end

  assign bus.scroll_row = scroll_q;
`else
  assign bus.scroll_row = '0;
`endif

endmodule

// File: doc/console_writer.md
Name: console_writer

Overview:
- Sequences writes into the 80x30 text buffer RAM (one byte per cell, address = y*COLS + x) from a byte stream, e.g. UART RX.
- Keeps the cursor position and interprets CR, LF and BS.
- Clears the whole buffer after reset and clears each new line before text lands on it.
- Drives the buffer's single write port; the VGA side keeps its own read port.

Parameters:
- COLS, 80, characters per row
- ROWS, 30, rows on screen
- ADDR_W, 12, buffer address width; must satisfy COLS*ROWS <= 2^ADDR_W
- BLANK, 8'h20, fill character used for clears

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  character byte
- in_valid  in  1  in_data valid
- in_ready  out  1  writer can accept; combinational, equal to (state==IDLE)
- wr_en  out  1  buffer write strobe, registered
- wr_addr  out  ADDR_W  buffer write address, registered
- wr_data  out  8  buffer write data, registered
- cursor_x  out  7  current column, 0..COLS-1
- cursor_y  out  5  current row, 0..ROWS-1
- scroll_row  out  5  display top-row offset (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high rst): state=CLEAR_ALL, cnt=0, cursor_x=0, cursor_y=0, wr_en=0, wr_addr=0, wr_data=0, scroll_row=0, in_ready=0.
- A character is accepted on a clock edge where in_valid & in_ready. in_data must be held while in_valid=1 and in_ready=0; it is not sampled then.
- CLEAR_ALL: each edge registers wr_en=1, wr_addr=cnt, wr_data=BLANK, then cnt++.
  - The edge writing cnt=COLS*ROWS-1 moves to IDLE.
  - Exactly 2400 write cycles (defaults); in_ready rises after the last of them.
- IDLE, nothing accepted: wr_en←0.
- IDLE, accepted byte, handled on the accept edge:
  - Printable, 0x20..0x7E:
    - Registers wr_en=1, wr_addr=cursor_y*COLS+cursor_x, wr_data=byte.
    - If cursor_x<COLS-1: cursor_x++.
    - Else (last column): cursor_x=0, then row advance.
  - 0x0A (LF): cursor_x=0, row advance, wr_en=0.
  - 0x0D (CR): cursor_x=0, wr_en=0; row unchanged.
  - 0x08 (BS): if cursor_x>0 then cursor_x--, else unchanged. No write; the cell is not erased.
  - Any other byte: consumed and ignored, wr_en=0.
- Row advance:
  - cursor_y ← (cursor_y==ROWS-1) ? 0 : cursor_y+1.
  - state←CLEAR_LINE, cnt←0.
- CLEAR_LINE: on the COLS following edges, registers wr_en=1, wr_addr=cursor_y*COLS+cnt, wr_data=BLANK, cnt++.
  - The edge writing cnt=COLS-1 returns to IDLE.
  - in_ready is low for exactly COLS cycles after an accept that caused a row advance.
- Address arithmetic: computed at ADDR_W bits. Max address COLS*ROWS-1 (2399); no overflow permitted.
- Write latency: the buffer sees the write in the cycle after the accept edge. Cursor outputs update on the same edge.
- Mid-operation reset: rst during CLEAR_LINE or IDLE aborts immediately and restarts CLEAR_ALL from address 0.

Optional Feature:
- Macro: CONSOLE_SCROLL_EN.
- Defined:
  - An internal wrapped flag sets on the first row advance from ROWS-1 to 0; cleared by reset.
  - On every row advance with wrapped set (including the setting one), scroll_row ← (new cursor_y + 1) mod ROWS.
  - The display fetches physical row (r + scroll_row) mod ROWS for screen row r, so the newest line appears at the bottom.
- Undefined: scroll_row is tied to 0. The cursor still wraps to row 0 and overwrites from the top after its line clear.

Test Plan:
- Release reset, in_valid=0 -> wr_en high for 2400 consecutive cycles, addr 0..2399, data 0x20; in_ready=1 on the next cycle.
- Send "Hi" (0x48, 0x69) back-to-back -> writes (0,0x48), (1,0x69) on consecutive cycles; cursor_x=2, in_ready stays 1.
- At cursor (0,0), send 80 printable bytes -> char 80 written to addr 79; then writes 80..159 of 0x20; in_ready low 80 cycles; cursor=(0,1).
- Cursor (5,29), send LF -> 80 blank writes to addr 0..79, cursor=(0,0). With CONSOLE_SCROLL_EN, scroll_row=1; without it, scroll_row=0.
- Cursor (3,2): send BS, BS, BS, BS, CR, 0x07 -> cursor_x 2,1,0,0,0,0; no wr_en pulses; cursor_y stays 2.
- Assert rst for 1 cycle mid CLEAR_LINE (cnt=40) -> cursor=(0,0), CLEAR_ALL restarts at addr 0, in_ready=0 until it completes.
